pipe_multiplier: RTL

PIPE_MULTIPLIER -- requirements
Module: pipe_multiplier

---
 rtl/pipe_multiplier.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_multiplier.sv
// Valid/ready pipelined multiplier with per-beat signed/unsigned selection.
// Define MULT_ACC_EN to compile in the wrapping accumulator, acc_mode and an ACC_WIDTH-wide z.
module pipe_multiplier #(
  parameter int DATA_WIDTH  = 18,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_WIDTH   = 48
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   x,
  input  logic [DATA_WIDTH-1:0]   y,
  input  logic                    sgn,
`ifdef MULT_ACC_EN
  input  logic                    acc_mode,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef MULT_ACC_EN
  output logic [ACC_WIDTH-1:0]    z
`else
  output logic [2*DATA_WIDTH-1:0] z
`endif
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int N  = PIPE_STAGES;
  localparam int SN = (N > 1) ? N - 1 : 1;
`ifdef MULT_ACC_EN
  localparam int DN = SN;
`else
  localparam int DN = N;
`endif

  generate
    if (N < 1 || N > 4 || ACC_WIDTH < PW) begin : g_param_check
      $error("pipe_multiplier: PIPE_STAGES must be 1..4 and ACC_WIDTH >= 2*DATA_WIDTH");
    end
  endgenerate

  // Exact 2W-bit product: each operand widened by one bit (sign or zero) so one signed multiply covers both modes.
  function automatic logic [PW-1:0] mul_full(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic                  s);
    logic signed [DATA_WIDTH:0] sa;
    logic signed [DATA_WIDTH:0] sb;
    logic signed [PW+1:0]       p;
    sa = {s & a[DATA_WIDTH-1], a};
    sb = {s & b[DATA_WIDTH-1], b};
    p  = (PW+2)'(sa) * (PW+2)'(sb);
    return p[PW-1:0];
  endfunction

  logic                  vld_p  [1:N];
  logic                  sgn_p  [1:SN];
  logic [PW-1:0]         data_p [1:DN];
  logic [PW-1:0]         din_p0;
  logic [PW-1:0]         prod_p1;
  logic                  stall;

  assign stall     = vld_p[N] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_p[N];

  // p0 -> p1: a single-stage pipe multiplies at the input, deeper pipes register the raw operands first
  assign din_p0  = (N == 1) ? mul_full(x, y, sgn) : {x, y};
  // p1 -> p2: multiply the registered operands
  assign prod_p1 = mul_full(data_p[1][PW-1:DATA_WIDTH], data_p[1][DATA_WIDTH-1:0], sgn_p[1]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 1; k <= N; k++) begin
        vld_p[k] <= 1'b0;
      end
      for (int k = 1; k <= SN; k++) begin
        sgn_p[k] <= 1'b0;
      end
      for (int k = 1; k <= DN; k++) begin
        data_p[k] <= '0;
      end
    end else if (!stall) begin
      vld_p[1] <= in_valid;
      for (int k = 2; k <= N; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      if (in_valid) begin
        sgn_p[1]  <= sgn;
        data_p[1] <= din_p0;
      end
      for (int k = 2; k <= SN; k++) begin
        if (vld_p[k-1]) sgn_p[k] <= sgn_p[k-1];
      end
      // Data only moves with a valid beat so z holds across bubbles
      for (int k = 2; k <= DN; k++) begin
        if (vld_p[k-1]) data_p[k] <= (k == 2) ? prod_p1 : data_p[k-1];
      end
    end
  end

`ifdef MULT_ACC_EN
  function automatic logic [ACC_WIDTH-1:0] acc_extend(input logic [PW-1:0] p, input logic s);
    logic signed [PW:0] t;
    t = {s & p[PW-1], p};
    return ACC_WIDTH'(t);
  endfunction

  logic                  mode_p [1:SN];
  logic                  vld_fin;
  logic                  sgn_fin;
  logic                  mode_fin;
  logic [PW-1:0]         prod_fin;
  logic [ACC_WIDTH-1:0]  acc_ext;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [ACC_WIDTH-1:0]  acc_q;

  // Final stage is the accumulator itself; these pick what is entering it this cycle
  assign vld_fin  = (N == 1) ? in_valid : vld_p[SN];
  assign sgn_fin  = (N == 1) ? sgn      : sgn_p[SN];
  assign mode_fin = (N == 1) ? acc_mode : mode_p[SN];
  assign prod_fin = (N == 1) ? din_p0   : ((N == 2) ? prod_p1 : data_p[DN]);
  assign acc_ext  = acc_extend(prod_fin, sgn_fin);
  assign acc_next = mode_fin ? acc_q + acc_ext : acc_ext;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 1; k <= SN; k++) begin
        mode_p[k] <= 1'b0;
      end
      acc_q <= '0;
    end else if (!stall) begin
      if (in_valid) mode_p[1] <= acc_mode;
      for (int k = 2; k <= SN; k++) begin
        if (vld_p[k-1]) mode_p[k] <= mode_p[k-1];
      end
      if (vld_fin) acc_q <= acc_next;
    end
  end

  assign z = acc_q;
`else
  assign z = data_p[N];
`endif

endmodule
